// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit path.
package i2s_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } ser_state_t;

  // bclk periods between the lrclk edge and the MSB
  localparam int unsigned I2S_OFFSET = 1;

endpackage

// File: rtl/i2s_edge_detect.sv
// bclk edge detection and framed lrclk change detection in the clk domain.
module i2s_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic bclk,
  input  logic lrclk,
  output logic bclk_fall,
  output logic bclk_rise,
  output logic lr_change,
  output logic lr_now,
  output logic primed
);

  logic bclk_prev;
  logic lrclk_prev;

  // bclk_prev resets low so a high bclk at release only looks like a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_prev  <= 1'b0;
      lrclk_prev <= 1'b0;
      primed     <= 1'b0;
    end else begin
      bclk_prev <= bclk;
      if (bclk_fall) begin
        lrclk_prev <= lrclk;
        primed     <= 1'b1;
      end
    end
  end

  assign bclk_fall = bclk_prev & ~bclk;
  assign bclk_rise = ~bclk_prev & bclk;
  assign lr_change = bclk_fall & primed & (lrclk ^ lrclk_prev);
  assign lr_now    = lrclk;

endmodule

// File: rtl/i2s_serializer.sv
// I2S transmitter: buffers stereo pairs and shifts them MSB-first, slaved to bclk/lrclk.
module i2s_serializer
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bclk,
  input  logic             lrclk,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             valid,
  output logic             ready,
  output logic             sdata,
  output logic             underrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH + I2S_OFFSET + 1);

  logic bclk_fall;
  logic bclk_rise;
  logic lr_change;
  logic lr_now;
  logic primed;
  logic unused_edge;

  i2s_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .bclk_fall(bclk_fall),
    .bclk_rise(bclk_rise),
    .lr_change(lr_change),
    .lr_now   (lr_now),
    .primed   (primed)
  );

  assign unused_edge = bclk_rise | primed;

  ser_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
  logic             full_q, full_d;
  logic             sdata_d;
  logic             underrun_d;
  logic             accept;
  chan_t            new_chan;

  assign accept   = valid & ready;
  assign new_chan = chan_t'(lr_now);

  // Next-state: buffering first (on pre-accept state), then the shifter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    frame_l_d  = frame_l_q;
    frame_r_d  = frame_r_q;
    full_d     = full_q;
    sdata_d    = sdata;
    underrun_d = 1'b0;

    if (lr_change && (new_chan == CH_LEFT)) begin
      if (full_q) begin
        frame_l_d = hold_l_q;
        frame_r_d = hold_r_q;
        full_d    = 1'b0;
      end else begin
        frame_l_d  = '0;
        frame_r_d  = '0;
        underrun_d = 1'b1;
      end
    end

    if (accept) begin
      hold_l_d = left;
      hold_r_d = right;
      full_d   = 1'b1;
    end

    if (lr_change) begin
      state_d = ARM;
      shreg_d = (new_chan == CH_LEFT) ? frame_l_d : frame_r_q;
      cnt_d   = CNT_W'(WIDTH);
      sdata_d = 1'b0;
    end else if (bclk_fall) begin
      case (state_q)
        IDLE: sdata_d = 1'b0;
        ARM, SHIFT: begin
          if (state_q == SHIFT && cnt_q == '0) begin
            state_d = IDLE;
            sdata_d = 1'b0;
          end else begin
            state_d = SHIFT;
            sdata_d = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          sdata_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      frame_l_q <= '0;
      frame_r_q <= '0;
      full_q    <= 1'b0;
      ready     <= 1'b1;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      frame_l_q <= frame_l_d;
      frame_r_q <= frame_r_d;
      full_q    <= full_d;
      ready     <= ~full_d;
      sdata     <= sdata_d;
      underrun  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_i2s_serializer.sv
// Directed bench for i2s_serializer: WIDTH=8, bclk = 8 clk, 16 bclk per channel.
module tb_i2s_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bclk;
  logic       lrclk;
  logic [7:0] left;
  logic [7:0] right;
  logic       valid;
  logic       ready;
  logic       sdata;
  logic       underrun;

  int tests  = 0;
  int fails  = 0;
  int ur_cnt = 0;
  int n_acc  = 0;
  bit drop_after = 1'b1;

  logic [15:0] bits;
  logic        ur_first;

  i2s_serializer #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .left    (left),
    .right   (right),
    .valid   (valid),
    .ready   (ready),
    .sdata   (sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underrun === 1'b1) ur_cnt++;

  function automatic logic [15:0] exp_slot(input logic [7:0] w);
    return {1'b0, w, 7'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clk; tracks handshakes that complete on this edge
  task automatic tick();
    logic acc;
    acc = (valid === 1'b1) && (ready === 1'b1);
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      if (drop_after) valid = 1'b0;
      else begin
        left  = left + 8'd1;
        right = right + 8'd1;
      end
    end
  endtask

  task automatic bclk_cycle(input logic lr, output logic sd, output logic ur);
    lrclk = lr;
    bclk  = 1'b0;
    tick();
    @(negedge clk);
    sd = sdata;
    ur = underrun;
    repeat (3) tick();
    bclk = 1'b1;
    repeat (4) tick();
  endtask

  task automatic slot(input logic lr, input int n, output logic [15:0] b, output logic urf);
    logic sd, ur;
    b   = '0;
    urf = 1'b0;
    for (int i = 0; i < n; i++) begin
      bclk_cycle(lr, sd, ur);
      b = {b[14:0], sd};
      if (i == 0) urf = ur;
    end
  endtask

  task automatic push(input logic [7:0] l, input logic [7:0] r);
    left       = l;
    right      = r;
    valid      = 1'b1;
    drop_after = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bclk  = 1'b1;
    lrclk = 1'b1;
    valid = 1'b0;
    left  = '0;
    right = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sdata", 16'(sdata), 16'h0);
    check("rst_ready", 16'(ready), 16'h1);
    check("rst_underrun", 16'(underrun), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // first fall only primes: no output
    slot(1'b1, 16, bits, ur_first);
    check("prime_slot", bits, 16'h0);

    push(8'hA5, 8'h3C);
    check("ready_after_push", 16'(ready), 16'h0);
    slot(1'b0, 16, bits, ur_first);
    check("A5_left", bits, exp_slot(8'hA5));
    check("ready_after_left", 16'(ready), 16'h1);
    slot(1'b1, 16, bits, ur_first);
    check("3C_right", bits, exp_slot(8'h3C));

    // streaming with valid held high
    n_acc      = 0;
    left       = 8'h01;
    right      = 8'h81;
    valid      = 1'b1;
    drop_after = 1'b0;
    tick();
    check("stream_ready_low", 16'(ready), 16'h0);
    slot(1'b0, 16, bits, ur_first); check("s01", bits, exp_slot(8'h01));
    slot(1'b1, 16, bits, ur_first); check("s81", bits, exp_slot(8'h81));
    check("stream_ready_mid", 16'(ready), 16'h0);
    slot(1'b0, 16, bits, ur_first); check("s02", bits, exp_slot(8'h02));
    slot(1'b1, 16, bits, ur_first); check("s82", bits, exp_slot(8'h82));
    slot(1'b0, 16, bits, ur_first); check("s03", bits, exp_slot(8'h03));
    slot(1'b1, 16, bits, ur_first); check("s83", bits, exp_slot(8'h83));
    valid      = 1'b0;
    drop_after = 1'b1;
    check("stream_accepts", 16'(n_acc), 16'd4);
    slot(1'b0, 16, bits, ur_first); check("s04", bits, exp_slot(8'h04));
    slot(1'b1, 16, bits, ur_first); check("s84", bits, exp_slot(8'h84));
    check("ur_none", 16'(ur_cnt), 16'd0);

    // underrun: nothing buffered at left start
    slot(1'b0, 16, bits, ur_first);
    check("ur_left", bits, 16'h0);
    check("ur_pulse", 16'(ur_first), 16'h1);
    check("ur_count1", 16'(ur_cnt), 16'd1);
    slot(1'b1, 16, bits, ur_first);
    check("ur_right", bits, 16'h0);
    push(8'h5A, 8'hC3);
    slot(1'b0, 16, bits, ur_first); check("after_ur_5A", bits, exp_slot(8'h5A));
    slot(1'b1, 16, bits, ur_first); check("after_ur_C3", bits, exp_slot(8'hC3));
    check("ur_count_still1", 16'(ur_cnt), 16'd1);

    // short left slot truncates the word
    push(8'hFF, 8'h81);
    slot(1'b0, 4, bits, ur_first);
    check("short_left", bits, 16'h0007);
    slot(1'b1, 16, bits, ur_first);
    check("short_next_right", bits, exp_slot(8'h81));

    // accept in the same clk as an empty left transition
    left       = 8'h66;
    right      = 8'h99;
    valid      = 1'b1;
    drop_after = 1'b1;
    slot(1'b0, 16, bits, ur_first);
    check("sim_left", bits, 16'h0);
    check("sim_pulse", 16'(ur_first), 16'h1);
    check("sim_accepted", 16'(valid), 16'h0);
    slot(1'b1, 16, bits, ur_first); check("sim_right", bits, 16'h0);
    slot(1'b0, 16, bits, ur_first); check("sim_66", bits, exp_slot(8'h66));
    slot(1'b1, 16, bits, ur_first); check("sim_99", bits, exp_slot(8'h99));
    check("ur_count2", 16'(ur_cnt), 16'd2);

    // asynchronous reset mid-word
    push(8'hFF, 8'hFF);
    slot(1'b0, 3, bits, ur_first);
    check("pre_rst_bits", bits, 16'h0003);
    check("pre_rst_sdata", 16'(sdata), 16'h1);
    push(8'hFF, 8'hFF);
    check("pre_rst_ready", 16'(ready), 16'h0);
    rst_n = 1'b0;
    #1;
    check("async_sdata", 16'(sdata), 16'h0);
    check("async_ready", 16'(ready), 16'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slot(1'b0, 16, bits, ur_first);
    check("post_rst_level", bits, 16'h0);
    check("post_rst_ready", 16'(ready), 16'h1);
    push(8'h12, 8'h34);
    slot(1'b1, 16, bits, ur_first); check("post_rst_right", bits, 16'h0);
    slot(1'b0, 16, bits, ur_first); check("post_rst_12", bits, exp_slot(8'h12));
    slot(1'b1, 16, bits, ur_first); check("post_rst_34", bits, exp_slot(8'h34));
    check("ur_count_final", 16'(ur_cnt), 16'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_serializer.md
Name: i2s_serializer

Overview:
- I2S transmitter: takes parallel stereo sample pairs through a valid/ready handshake and shifts them out MSB-first on a serial data line.
- Slave to externally supplied bclk/lrclk; it never generates clocks.
- Inverse of the in-line bit-serial processing blocks. It produces the stream they consume: standard I2S framing, MSB one bclk after the lrclk edge, data changing on bclk falling edges.
- Sits at the output of the sample pipeline, in front of the first bit-serial processing stage or the codec pin.

Parameters:
- WIDTH, 24, sample width in bits per channel.

Ports:
- clk  input  1  system clock; bclk/lrclk are oversampled in this domain.
- rst_n  input  1  asynchronous active-low reset.
- bclk  input  1  I2S bit clock, already synchronous to clk.
- lrclk  input  1  I2S word select: 0 = left, 1 = right.
- left  input  WIDTH  left sample, two's complement.
- right  input  WIDTH  right sample, two's complement.
- valid  input  1  sample pair on left/right is valid.
- ready  output  1  holding register can accept a pair.
- sdata  output  1  serial I2S data.
- underrun  output  1  one-clk pulse: left frame started with no pair buffered.

Behaviour:
- Reset values: sdata=0, ready=1, underrun=0. Holding and frame registers cleared, bit counter idle, primed=0.
- Reset is asynchronous. Reset mid-word aborts the word; sdata returns to 0 immediately.
- Edge detect: register bclk each clk.
  - Fall = prev & !bclk.
  - Rise = !prev & bclk.
  - All state below updates only on a fall; rises are ignored.
- On each fall:
  - Sample lrclk into lrclk_prev.
  - Transition = primed & (lrclk ^ lrclk_prev).
  - Set primed=1. The first fall after reset never counts as a transition, so a partial frame is never emitted.
- States: IDLE, ARM, SHIFT.
  - IDLE: sdata=0.
  - Transition from any state -> ARM. Select channel = new lrclk, load shift register from the frame register of that channel, bit counter = WIDTH.
  - ARM, next fall -> SHIFT. Drive the MSB on sdata (I2S one-bclk offset); counter decrements.
  - SHIFT, each fall: drive next bit MSB..LSB. After the LSB has been driven (counter reaches 0), the next fall -> IDLE, sdata=0 (zero padding to slot end).
  - A transition while in ARM or SHIFT truncates the current word and restarts. A short slot never corrupts the next word.
- sdata is registered and changes exactly one clk after the clk in which the fall is detected.
- Buffering: one holding register (left, right, full flag) plus a frame register (left, right).
  - ready = !full, registered.
  - Accept when valid & ready: holding <= {left, right}, full=1. ready drops the following clk.
  - On a transition to left (lrclk 1->0), full: frame <= holding, full=0, ready=1 the next clk.
  - On a transition to left, empty: frame <= 0 and underrun pulses for one clk. The left and right words are both 0 for that stereo frame.
  - A transition to right uses frame.right. It never touches holding, so a pair is always sent coherently.
- Simultaneous accept and left-transition in the same clk while empty:
  - Underrun is evaluated on the pre-accept state: pulse asserted, frame = 0.
  - The accepted pair lands in holding for the next frame.
- valid without ready: data is ignored. Upstream holds it per the normal handshake.

Decomposition:
- Shared package i2s_pkg:
  - typedef chan_t enum {CH_LEFT=0, CH_RIGHT=1};
  - typedef ser_state_t {IDLE, ARM, SHIFT};
  - localparam I2S_OFFSET = 1.
- Sub-module i2s_edge_detect (clk, rst_n, bclk, lrclk -> bclk_fall, bclk_rise, lr_change, lr_now, primed). It is natural and reusable by the receive-side and bit-serial blocks.

Test Plan:
- WIDTH=8, bclk period 8 clk, 16 bclk per channel. Push {left=8'hA5, right=8'h3C}, then run a full frame -> after lrclk falls, sdata is 0 for one bclk, then 1,0,1,0,0,1,0,1, then zeros to slot end. Right slot: 0 for one bclk, then 0,0,1,1,1,1,0,0.
- Hold valid=1 with an incrementing pair, left=8'h01/right=8'h81 and upward -> ready low between left-frame boundaries. Exactly one pair is consumed per frame, and words appear in order 01/81, 02/82, 03/83.
- No valid at a left-frame start -> underrun pulses once, one clk wide. sdata is all zeros for that frame. The next buffered pair plays in the following frame.
- lrclk toggles after only 4 bclk (short slot) while shifting 8'hFF -> the word truncates after the bits already sent. The new channel's MSB appears one bclk after the toggle.
- Assert rst_n low mid-word while sdata=1 -> sdata=0 and ready=1 asynchronously. After release, the first lrclk level is not treated as an edge: sdata stays 0 until the first real lrclk toggle.
- valid and a left transition in the same clk with holding empty -> underrun=1 that clk, the current frame outputs zeros, and the accepted pair plays in the next frame.
